// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Parametrised circular FIFO with synchronous flush; the occupancy count is
// exported so the fetch credit logic can use it directly.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // A push into a full FIFO is accepted only when a pop frees the slot.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (pop && (count_r != {CNT_W{1'b0}})) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    if (push && ((count_r != CNT_W'(DEPTH)) || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Pointer and occupancy state; flush wins over push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;

endmodule

// File: rtl/fetch_queue_unit.sv
// RV32I fetch stage: PC generation, credit-limited imem requests and an
// instruction queue to decode. Optional misaligned-redirect fault: FETCH_MISALIGN_FAULT_EN.
module fetch_queue_unit #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = {XLEN{1'b0}},
  parameter int              IQ_DEPTH        = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_fault
);

  import fetch_pkg::*;

  localparam int QCW = $clog2(IQ_DEPTH + 1);
  localparam int PCW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0]   fetch_pc_r;
  logic [PCW-1:0]    drop_cnt_r;
  logic [PCW-1:0]    drop_nxt_s;
  logic              fault_r;
  logic [XLEN-1:0]   target_s;
  logic              req_fire_s;
  logic              deq_s;
  logic              enq_s;
  logic              resp_pop_s;
  logic [31:0]       credit_sum_s;

  logic [2*XLEN-1:0] q_head_s;
  logic              q_full_s;
  logic              q_empty_s;
  logic [QCW-1:0]    q_count_s;

  logic [XLEN-1:0]   pc_head_s;
  logic              pc_full_s;
  logic              pc_empty_s;
  logic [PCW-1:0]    inflight_s;

  // Issued-PC FIFO: holds one entry per unanswered request, dropped or not,
  // so its count is the in-flight count and its head always matches the next response.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (req_fire_s),
    .push_data (fetch_pc_r),
    .pop       (imem_resp_valid),
    .head_data (pc_head_s),
    .full      (pc_full_s),
    .empty     (pc_empty_s),
    .count     (inflight_s)
  );

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (IQ_DEPTH)
  ) u_inst_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (enq_s),
    .push_data ({pc_head_s, imem_resp_data}),
    .pop       (deq_s),
    .head_data (q_head_s),
    .full      (q_full_s),
    .empty     (q_empty_s),
    .count     (q_count_s)
  );

  // Request credit: every outstanding request must own a free queue slot.
  always_comb begin
    credit_sum_s   = 32'(q_count_s) + 32'(inflight_s);
    imem_req_valid = 1'b0;
    if (!reset && !fault_r && !pc_full_s && !q_full_s &&
        (credit_sum_s < 32'(IQ_DEPTH))) begin
      imem_req_valid = 1'b1;
    end else begin
      imem_req_valid = 1'b0;
    end
  end

  assign req_fire_s = imem_req_valid && imem_req_ready;
  assign deq_s      = inst_valid && inst_ready;
  assign resp_pop_s = imem_resp_valid && !pc_empty_s;

  // Response routing: drop while stale requests remain, else enqueue.
  always_comb begin
    enq_s = 1'b0;
    if (resp_pop_s && (drop_cnt_r == {PCW{1'b0}}) && !redirect_valid) begin
      enq_s = 1'b1;
    end else begin
      enq_s = 1'b0;
    end
  end

  // Redirect marks every request still unanswered after this cycle as stale.
  always_comb begin
    drop_nxt_s = drop_cnt_r;
    if (redirect_valid) begin
      drop_nxt_s = inflight_s + PCW'(req_fire_s) - PCW'(resp_pop_s);
    end else if (imem_resp_valid && (drop_cnt_r != {PCW{1'b0}})) begin
      drop_nxt_s = drop_cnt_r - PCW'(1);
    end else begin
      drop_nxt_s = drop_cnt_r;
    end
  end

  // PC and stale-response counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      drop_cnt_r <= {PCW{1'b0}};
    end else begin
      if (redirect_valid) begin
        fetch_pc_r <= target_s;
      end else if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + XLEN'(INSTR_BYTES);
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      drop_cnt_r <= drop_nxt_s;
    end
  end

`ifdef FETCH_MISALIGN_FAULT_EN
  assign target_s = redirect_target;

  // Fault follows the alignment of the most recent redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_r <= 1'b0;
    end else if (redirect_valid) begin
      fault_r <= is_misaligned(redirect_target[1:0]);
    end else begin
      fault_r <= fault_r;
    end
  end
`else
  assign target_s = redirect_target & ~XLEN'(2'b11);

  // Fault disabled in this build: register held at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= 1'b0;
    end
  end
`endif

  assign imem_req_addr = fetch_pc_r;
  assign fetch_pc      = fetch_pc_r;
  assign fetch_fault   = fault_r;
  assign inst_valid    = !q_empty_s && !reset;
  assign inst_pc       = q_head_s[2*XLEN-1:XLEN];
  assign inst_data     = inst_valid ? q_head_s[XLEN-1:0] : XLEN'(NOP_INSTR);

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with an in-order imem response model.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic [31:0] fetch_pc;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_due = 0;
  int lat = 1;
  int fires = 0;
  int fires_before = 0;
  int nrand = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] del_pc[$];
  logic [31:0] del_data[$];
  logic [31:0] exp_next;
  logic [31:0] tgt;
  logic [31:0] p;
  logic [31:0] d;
  logic        redir;

  fetch_queue_unit #(
    .XLEN            (32),
    .RESET_PC        (32'h0000_0100),
    .IQ_DEPTH        (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_pc         (inst_pc),
    .inst_data       (inst_data),
    .fetch_pc        (fetch_pc),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'd7) ^ 32'h0013_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive due response, sample handshakes, advance past the edge.
  task automatic tick();
    logic        fire_l;
    logic [31:0] addr_l;
    logic        deq_l;
    logic [31:0] dpc_l;
    logic [31:0] ddat_l;
    int          due_l;
    if (!reset && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = imem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
    #1;
    fire_l = imem_req_valid && imem_req_ready;
    addr_l = imem_req_addr;
    deq_l  = inst_valid && inst_ready;
    dpc_l  = inst_pc;
    ddat_l = inst_data;
    @(posedge clk);
    #1;
    if (fire_l) begin
      due_l = cyc + lat;
      if (due_l <= last_due) due_l = last_due + 1;
      last_due = due_l;
      pend_addr.push_back(addr_l);
      pend_due.push_back(due_l);
      fires++;
    end
    if (deq_l) begin
      del_pc.push_back(dpc_l);
      del_data.push_back(ddat_l);
    end
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    @(posedge clk);
    #1;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'h0000_0100);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    del_pc.delete();
    del_data.delete();
    fires = 0;
    last_due = cyc;
    #1;
  endtask

  task automatic check_del(input string tag, input logic [31:0] exp_pcs[$]);
    check({tag, "_count"}, 32'(del_pc.size()), 32'(exp_pcs.size()));
    for (int i = 0; i < exp_pcs.size() && i < del_pc.size(); i++) begin
      check({tag, "_pc"}, del_pc[i], exp_pcs[i]);
      check({tag, "_data"}, del_data[i], imem_word(exp_pcs[i]));
    end
  endtask

  initial begin
    // Streaming from RESET_PC with a 1-cycle imem.
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    do_reset();
    check("s_fetch_pc", fetch_pc, 32'h0000_0100);
    check("s_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("s_req_addr", imem_req_addr, 32'h0000_0100);
    check("s_inst_valid", {31'd0, inst_valid}, 32'd0);
    ticks(10);
    check_del("stream", '{32'h100, 32'h104, 32'h108, 32'h10C,
                          32'h110, 32'h114, 32'h118, 32'h11C});

    // Decode stalled: exactly four fetches, then drain in order.
    inst_ready = 1'b0;
    do_reset();
    ticks(5);
    check("full_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("full_fetch_pc", fetch_pc, 32'h0000_0110);
    check("full_inst_pc", inst_pc, 32'h0000_0100);
    check("full_inst_data", inst_data, imem_word(32'h100));
    check("full_fires", 32'(fires), 32'd4);
    check("full_inflight", 32'(pend_addr.size()), 32'd0);
    ticks(3);
    check("hold_fires", 32'(fires), 32'd4);
    check("hold_req_valid", {31'd0, imem_req_valid}, 32'd0);
    inst_ready = 1'b1;
    del_pc.delete(); del_data.delete();
    ticks(8);
    check_del("drain", '{32'h100, 32'h104, 32'h108, 32'h10C,
                         32'h110, 32'h114, 32'h118, 32'h11C});

    // Redirect with two stale requests in flight and two entries queued.
    lat = 3; inst_ready = 1'b0;
    do_reset();
    ticks(6);
    check("r1_pre_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("r1_pre_inflight", 32'(pend_addr.size()), 32'd2);
    redirect_valid = 1'b1; redirect_target = 32'h0000_0200; inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("r1_fetch_pc", fetch_pc, 32'h0000_0200);
    check("r1_req_blocked", {31'd0, imem_req_valid}, 32'd0);
    check("r1_flushed", {31'd0, inst_valid}, 32'd0);
    tick();
    check("r1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("r1_req_addr", imem_req_addr, 32'h0000_0200);
    ticks(3);
    check("r1_no_stale", {31'd0, inst_valid}, 32'd0);
    tick();
    check("r1_first_valid", {31'd0, inst_valid}, 32'd1);
    check("r1_first_pc", inst_pc, 32'h0000_0200);
    ticks(2);
    check_del("r1", '{32'h100, 32'h200, 32'h204});

    // Redirect coinciding with a response and a fired request.
    lat = 1; inst_ready = 1'b1;
    do_reset();
    ticks(3);
    redirect_valid = 1'b1; redirect_target = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    check("r2_fetch_pc", fetch_pc, 32'h0000_0300);
    check("r2_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("r2_req_addr", imem_req_addr, 32'h0000_0300);
    check("r2_flushed", {31'd0, inst_valid}, 32'd0);
    tick();
    check("r2_drop", {31'd0, inst_valid}, 32'd0);
    tick();
    check("r2_first_valid", {31'd0, inst_valid}, 32'd1);
    check("r2_first_pc", inst_pc, 32'h0000_0300);
    check("r2_first_data", inst_data, imem_word(32'h300));
    ticks(2);
    check_del("r2", '{32'h100, 32'h104, 32'h300, 32'h304});

    // PC wraps modulo 2^32.
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    del_pc.delete(); del_data.delete();
    ticks(6);
    check_del("wrap", '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8});

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_target = 32'h0000_0202;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_FAULT_EN
    check("mis_fault", {31'd0, fetch_fault}, 32'd1);
    check("mis_fetch_pc", fetch_pc, 32'h0000_0202);
    check("mis_req_blocked", {31'd0, imem_req_valid}, 32'd0);
    fires_before = fires;
    ticks(4);
    check("mis_no_fires", 32'(fires), 32'(fires_before));
    check("mis_inst_valid", {31'd0, inst_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_target = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    check("mis_clear", {31'd0, fetch_fault}, 32'd0);
    check("mis_resume_addr", imem_req_addr, 32'h0000_0300);
    check("mis_resume_valid", {31'd0, imem_req_valid}, 32'd1);
    del_pc.delete(); del_data.delete();
    ticks(6);
    check_del("mis", '{32'h300, 32'h304, 32'h308, 32'h30C});
`else
    check("mis_fault", {31'd0, fetch_fault}, 32'd0);
    check("mis_fetch_pc", fetch_pc, 32'h0000_0200);
    del_pc.delete(); del_data.delete();
    ticks(6);
    check_del("mis", '{32'h200, 32'h204, 32'h208, 32'h20C});
`endif

    // Reset asserted mid-stream takes effect without a clock edge.
    reset = 1'b1;
    #1;
    check("async_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("async_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("async_fetch_pc", fetch_pc, 32'h0000_0100);

    // Random ready/latency/redirect soak: strict +4 between redirects.
    do_reset();
    exp_next = 32'h0000_0100;
    for (int k = 0; k < 1000; k++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 4);
      redir = ($urandom_range(0, 39) == 0);
      tgt = $urandom() & 32'hFFFF_FFFC;
      redirect_valid = redir;
      redirect_target = tgt;
      tick();
      redirect_valid = 1'b0;
      while (del_pc.size() > 0) begin
        p = del_pc.pop_front();
        d = del_data.pop_front();
        check("rnd_pc", p, exp_next);
        check("rnd_data", d, imem_word(p));
        exp_next = p + 32'd4;
        nrand++;
      end
      if (redir) exp_next = tgt;
    end
    check("rnd_progress", {31'd0, (nrand > 100)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
